swt_led_ctrl: RTL and testbench

Parametrised switch-to-LED controller for the lab board top level, replacing the purely combinational switch/LED logic block. Each switch is synchronised and debounced, and the LEDs are driven from registers in one of four selectable display modes. The block sits between the raw board switch pins and the LED pins, and exports the debounced switch vector for other lab blocks.

---
 rtl/swt_led_pkg.sv | 10 +
 rtl/debounce_bit.sv | 46 ++++
 rtl/swt_led_ctrl.sv | 89 ++++++++
 tb/tb_swt_led_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/swt_led_pkg.sv
// Shared definitions for the switch-to-LED controller.
// Holds the 2-bit display mode encodings driven on the mode input.
package swt_led_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'd0;
  localparam logic [1:0] MODE_PASS  = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: a 2-flop synchroniser followed by a debounce counter.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   swt      : raw asynchronous switch pin
//   db       : accepted (debounced) value
//   acc      : high in the cycle whose edge will load a new db value
module debounce_bit #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic swt,
  output logic db,
  output logic acc
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive earlier edges already saw s2 != db,
  // so the DB_CYCLES-th differing edge is the one that commits.
  assign acc = (s2 != db) && (cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= swt;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (acc) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/swt_led_ctrl.sv
// Switch-to-LED controller: debounces every switch and drives the LEDs from
// a register in one of four display modes (LOGIC, PASS, BLINK, COUNT).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   swt      : raw switch pins (WIDTH)
//   mode     : display mode select, sampled every cycle
//   led      : registered LED drive (WIDTH)
//   swt_db   : debounced switch vector (WIDTH)
//   chg      : one-cycle pulse in the cycle swt_db has just changed
module swt_led_ctrl
  import swt_led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] swt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] swt_db,
  output logic             chg
);

  localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] evt_cnt;
  logic [WIDTH-1:0] led_nxt;
  logic [DW-1:0]    div;
  logic             blink;
  logic             any_acc;
  logic             l1, l3;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk (clk),
      .rst (rst),
      .swt (swt[i]),
      .db  (swt_db[i]),
      .acc (acc[i])
    );
  end

  // chg and evt_cnt update on the same edge as swt_db, so a chg cycle
  // already sees the incremented event count.
  assign any_acc = |acc;

  assign l1 = swt_db[1] & ~swt_db[2];
  assign l3 = swt_db[2] & swt_db[3];

  always_comb begin
    led_nxt = swt_db;
    case (mode)
      MODE_LOGIC: begin
        led_nxt[0] = ~swt_db[0];
        led_nxt[1] = l1;
        led_nxt[2] = l1 | l3;
        led_nxt[3] = l3;
      end
      MODE_PASS:  led_nxt = swt_db;
      MODE_BLINK: led_nxt = swt_db & {WIDTH{blink}};
      MODE_COUNT: led_nxt = evt_cnt;
      default:    led_nxt = swt_db;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg     <= 1'b0;
      evt_cnt <= '0;
      div     <= '0;
      blink   <= 1'b0;
      led     <= '0;
    end else begin
      chg <= any_acc;
      if (any_acc) evt_cnt <= evt_cnt + WIDTH'(1);
      if (div == DW'(BLINK_DIV - 1)) begin
        div   <= '0;
        blink <= ~blink;
      end else begin
        div <= div + DW'(1);
      end
      led <= led_nxt;
    end
  end

endmodule

// File: tb/tb_swt_led_ctrl.sv
// Bench for swt_led_ctrl (WIDTH=8, DB_CYCLES=4, BLINK_DIV=8): directed
// scenarios plus randomized switch/mode/reset traffic, checked every cycle
// against a window-based behavioural model.
module tb_swt_led_ctrl;

  localparam int W  = 8;
  localparam int DB = 4;
  localparam int BD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] swt;
  logic [1:0]   mode;
  logic [W-1:0] led;
  logic [W-1:0] swt_db;
  logic         chg;

  int checks = 0;
  int errors = 0;

  swt_led_ctrl #(.WIDTH(W), .DB_CYCLES(DB), .BLINK_DIV(BD)) dut (
    .clk    (clk),
    .rst    (rst),
    .swt    (swt),
    .mode   (mode),
    .led    (led),
    .swt_db (swt_db),
    .chg    (chg)
  );

  always #5 clk = ~clk;

  // Model: h[j] is the swt value sampled j+1 edges ago (zeros while in reset).
  // A bit is accepted when the last DB synchronised samples all disagree with
  // the accepted value; blink is the parity of (edges since reset)/BD.
  logic [W-1:0] h [0:DB];
  logic [W-1:0] m_db, m_led, m_evt;
  logic         m_chg;
  int           tcnt;

  function automatic logic [W-1:0] f_logic(input logic [W-1:0] d);
    logic [W-1:0] r;
    r    = d;
    r[0] = ~d[0];
    r[1] = d[1] & ~d[2];
    r[3] = d[2] & d[3];
    r[2] = r[1] | r[3];
    return r;
  endfunction

  task automatic model_step();
    logic [W-1:0] a;
    logic         bl;
    if (rst) begin
      m_db = '0; m_chg = 1'b0; m_evt = '0; m_led = '0; tcnt = 0;
      for (int j = 0; j <= DB; j++) h[j] = '0;
    end else begin
      for (int b = 0; b < W; b++) begin
        a[b] = 1'b1;
        for (int j = 1; j <= DB; j++) if (h[j][b] == m_db[b]) a[b] = 1'b0;
      end
      bl = ((tcnt / BD) % 2) == 1;
      case (mode)
        2'd0:    m_led = f_logic(m_db);
        2'd1:    m_led = m_db;
        2'd2:    m_led = bl ? m_db : '0;
        default: m_led = m_evt;
      endcase
      m_chg = (a != '0);
      m_db  = m_db ^ a;
      if (m_chg) m_evt = m_evt + 8'd1;
      tcnt++;
      for (int j = DB; j > 0; j--) h[j] = h[j-1];
      h[0] = swt;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_led", {24'd0, led}, {24'd0, m_led});
    chk("model_db",  {24'd0, swt_db}, {24'd0, m_db});
    chk("model_chg", {31'd0, chg}, {31'd0, m_chg});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  int           nchg;
  int           found;
  logic [W-1:0] prev, v;

  initial begin
    rst = 1'b1; swt = '0; mode = 2'd0;
    for (int j = 0; j <= DB; j++) h[j] = '0;
    m_db = '0; m_chg = 1'b0; m_evt = '0; m_led = '0; tcnt = 0;
    @(negedge clk);

    // Reset with all switches high, then exact acceptance latency.
    swt = 8'hFF;
    rst = 1'b1;
    tick();
    chk("rst_led", {24'd0, led}, 32'h0);
    tick();
    chk("rst_db", {24'd0, swt_db}, 32'h0);
    chk("rst_chg", {31'd0, chg}, 32'h0);
    rst = 1'b0;
    nchg = 0;
    for (int i = 1; i <= 5; i++) begin tick(); nchg += chg; end
    chk("rst_db_early", {24'd0, swt_db}, 32'h0);
    tick(); nchg += chg;
    chk("rst_db_edge5", {24'd0, swt_db}, 32'hFF);
    ticks(3);
    chk("rst_chg_once", nchg + chg, 32'd1);

    // LOGIC mode: result lands DB+2 edges after the first sample.
    do_reset(1);
    swt = '0; mode = 2'd0;
    ticks(8);
    chk("logic_00", {24'd0, led}, 32'h01);
    swt = 8'h02; ticks(6);
    chk("logic_02_early", {24'd0, led}, 32'h01);
    tick();
    chk("logic_02", {24'd0, led}, 32'h07);
    swt = 8'h0C; ticks(6);
    chk("logic_0c_early", {24'd0, led}, 32'h07);
    tick();
    chk("logic_0c", {24'd0, led}, 32'h0D);
    swt = 8'hA5; ticks(7);
    chk("logic_a5", {24'd0, led}, 32'hA0);

    // Glitch rejection: 3 cycles high is dropped, 4 cycles is accepted.
    swt = 8'h00; ticks(8);
    nchg = 0;
    swt = 8'h08; ticks(3);
    swt = 8'h00;
    for (int i = 0; i < 10; i++) begin tick(); nchg += chg; end
    chk("glitch_db", {24'd0, swt_db}, 32'h00);
    chk("glitch_chg", nchg, 32'd0);
    chk("glitch_led", {24'd0, led}, 32'h01);
    swt = 8'h08; ticks(4);
    swt = 8'h00; ticks(2);
    chk("hold4_db", {24'd0, swt_db}, 32'h08);

    // BLINK mode: led alternates 3C / 00 every BD cycles.
    do_reset(1);
    mode = 2'd2; swt = 8'h3C;
    ticks(8);
    prev = led; found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick();
      if (led != prev) found = 1;
    end
    chk("blink_found", found, 32'd1);
    v = led;
    chk("blink_val", {24'd0, (v == 8'h3C || v == 8'h00) ? 8'h01 : 8'h00}, 32'h01);
    for (int i = 0; i < 7; i++) tick();
    chk("blink_hold", {24'd0, led}, {24'd0, v});
    tick();
    chk("blink_flip", {24'd0, led}, {24'd0, v ^ 8'h3C});

    // COUNT mode: 5 accepted toggles, then 256 total wraps to zero.
    do_reset(1);
    mode = 2'd3; swt = '0;
    ticks(2);
    for (int i = 0; i < 5; i++) begin swt[0] = ~swt[0]; ticks(6); end
    ticks(2);
    chk("count_5", {24'd0, led}, 32'h05);
    for (int i = 0; i < 251; i++) begin swt[0] = ~swt[0]; ticks(6); end
    ticks(2);
    chk("count_wrap", {24'd0, led}, 32'h00);

    // Reset mid-debounce: partial count lost, full latency afterwards.
    do_reset(1);
    mode = 2'd1; swt = '0;
    ticks(8);
    swt = 8'h20; ticks(2);
    rst = 1'b1; nchg = 0;
    for (int i = 0; i < 2; i++) begin tick(); nchg += chg; end
    chk("mid_rst_db", {24'd0, swt_db}, 32'h00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); nchg += chg; end
    chk("mid_rst_db_early", {24'd0, swt_db}, 32'h00);
    chk("mid_rst_nochg", nchg, 32'd0);
    tick();
    chk("mid_rst_db_edge5", {24'd0, swt_db}, 32'h20);

    // Randomized traffic against the model.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(63) == 0) do_reset($urandom_range(2, 1));
      mode = 2'($urandom_range(3));
      if ($urandom_range(1) == 0) swt = 8'($urandom);
      else swt = swt ^ (8'd1 << $urandom_range(W - 1));
      ticks($urandom_range(8, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
